delta_stream_encoder: RTL and testbench



---
 rtl/delta_stream_encoder_pkg.sv | 9 +
 rtl/delta_stream_encoder_token_fifo.sv | 47 ++++
 rtl/delta_stream_encoder.sv | 77 +++++++
 tb/tb_delta_stream_encoder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/delta_stream_encoder_pkg.sv
// parameters: shared sample width, token layout and default short-delta width for the delta encoder.
package parameters;
    localparam int DATA_WIDTH = 8;
    localparam int SHORT_WIDTH_DEFAULT = 4;
    typedef struct packed {
        logic                  raw;
        logic [DATA_WIDTH-1:0] data;
    } token_t;
endpackage

// File: rtl/delta_stream_encoder_token_fifo.sv
// token_fifo: synchronous FIFO; head word reads as zero while empty so idle outputs stay clean.
module token_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic do_push, do_pop;
    assign full     = count_q == CW'(DEPTH);
    assign empty    = count_q == '0;
    assign count    = count_q;
    assign pop_data = empty ? '0 : mem[rd_q];
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= push_data;
    end
endmodule

// File: rtl/delta_stream_encoder.sv
// delta_stream_encoder: deserialises LSB-first bits into samples and emits short-delta or raw tokens through a FIFO.
module delta_stream_encoder
    import parameters::*;
#(
    parameter int DATA_WIDTH        = parameters::DATA_WIDTH,
    parameter int SHORT_WIDTH       = SHORT_WIDTH_DEFAULT,
    parameter int STARTER           = 0,
    parameter int FIFO_DEPTH        = 4,
    parameter int KEYFRAME_INTERVAL = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_bit,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_raw,
    output logic [DATA_WIDTH-1:0] out_data
);
    localparam int IW = $clog2(DATA_WIDTH);
    localparam int KW = KEYFRAME_INTERVAL > 1 ? $clog2(KEYFRAME_INTERVAL) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [IW-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, prev_q, prev_d;
    logic [KW-1:0] kf_q, kf_d;
    logic [DATA_WIDTH-1:0] word, delta;
    logic [DATA_WIDTH-SHORT_WIDTH:0] delta_hi;
    logic last, accept, complete, fits, raw, full, empty;
    logic [CW-1:0] fifo_count;
    logic [DATA_WIDTH:0] push_data, pop_data;
    always_comb begin
        last     = idx_q == IW'(DATA_WIDTH - 1);
        in_ready = !last || (fifo_count < CW'(FIFO_DEPTH));
        accept   = in_valid && in_ready;
        complete = accept && last;
        // the completing bit bypasses the shift register so the token is pushed on its own edge
        word     = {in_bit, shift_q[DATA_WIDTH-2:0]};
        delta    = word - prev_q;
        delta_hi = delta[DATA_WIDTH-1:SHORT_WIDTH-1];
        fits     = (&delta_hi) || !(|delta_hi);
        raw      = !fits || (KEYFRAME_INTERVAL > 0 && kf_q == '0);
        push_data = {raw, raw ? word : DATA_WIDTH'(delta[SHORT_WIDTH-1:0])};
        shift_d  = shift_q;
        if (accept) shift_d[idx_q] = in_bit;
        idx_d    = accept ? (last ? '0 : idx_q + 1'b1) : idx_q;
        prev_d   = complete ? word : prev_q;
        kf_d     = complete ? (kf_q == KW'(KEYFRAME_INTERVAL - 1) ? '0 : kf_q + 1'b1) : kf_q;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx_q   <= '0;
            shift_q <= '0;
            prev_q  <= DATA_WIDTH'(STARTER);
            kf_q    <= '0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
            prev_q  <= prev_d;
            kf_q    <= kf_d;
        end
    end
    token_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (complete && !full),
        .push_data (push_data),
        .pop       (out_ready && !empty),
        .pop_data  (pop_data),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );
    assign out_valid = !empty;
    assign out_raw   = pop_data[DATA_WIDTH];
    assign out_data  = pop_data[DATA_WIDTH-1:0];
endmodule

// File: tb/tb_delta_stream_encoder.sv
// tb_delta_stream_encoder: directed vectors into a scoreboard; plain encoder (a) and keyframe-3 encoder (b).
module tb_delta_stream_encoder;
    import parameters::*;
    logic clk = 0, reset_n = 0, in_bit = 0, in_valid = 0, sel = 0;
    logic out_ready_a = 0, out_ready_b = 1;
    logic in_ready_a, in_ready_b, out_valid_a, out_valid_b, out_raw_a, out_raw_b;
    logic [7:0] out_data_a, out_data_b;
    token_t exp_a[$], exp_b[$];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    delta_stream_encoder #(.DATA_WIDTH(8), .SHORT_WIDTH(4), .STARTER(0), .FIFO_DEPTH(2), .KEYFRAME_INTERVAL(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .in_bit(in_bit), .in_valid(in_valid && !sel), .in_ready(in_ready_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_raw(out_raw_a), .out_data(out_data_a));

    delta_stream_encoder #(.DATA_WIDTH(8), .SHORT_WIDTH(4), .STARTER(0), .FIFO_DEPTH(2), .KEYFRAME_INTERVAL(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_bit(in_bit), .in_valid(in_valid && sel), .in_ready(in_ready_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_raw(out_raw_b), .out_data(out_data_b));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic token_t tk(input logic r, input logic [7:0] d);
        return {r, d};
    endfunction

    always @(negedge clk) begin
        if (reset_n && out_valid_a && out_ready_a) begin
            if (exp_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL tok_a unexpected got %0h", {out_raw_a, out_data_a});
            end else check("tok_a", 32'({out_raw_a, out_data_a}), 32'(exp_a.pop_front()));
        end
        if (reset_n && out_valid_b && out_ready_b) begin
            if (exp_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL tok_b unexpected got %0h", {out_raw_b, out_data_b});
            end else check("tok_b", 32'({out_raw_b, out_data_b}), 32'(exp_b.pop_front()));
        end
    end

    task automatic send_bit(input logic b);
        int n = 0;
        in_bit = b;
        in_valid = 1;
        @(negedge clk);
        while (!(sel ? in_ready_b : in_ready_a) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n == 100) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout got 0 expected 1");
        end
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] v, input logic push, input token_t t);
        for (int i = 0; i < 8; i++) begin
            if (i == 7 && push) begin
                if (sel) exp_b.push_back(t);
                else exp_a.push_back(t);
            end
            send_bit(v[i]);
        end
        in_valid = 0;
    endtask

    task automatic pulse_reset();
        in_valid = 0;
        reset_n = 0;
        @(posedge clk); #1;
        reset_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        check("rst_out_valid", 32'(out_valid_a), 0);
        check("rst_out_raw", 32'(out_raw_a), 0);
        check("rst_out_data", 32'(out_data_a), 0);
        check("rst_in_ready", 32'(in_ready_a), 1);
        out_ready_a = 1;
        send_byte(8'h03, 1, tk(0, 8'h03));
        check("latency_valid", 32'(out_valid_a), 1);
        send_byte(8'h0A, 1, tk(0, 8'h07));
        send_byte(8'h02, 1, tk(0, 8'h08));
        send_byte(8'h0A, 1, tk(1, 8'h0A));
        send_byte(8'hF0, 1, tk(1, 8'hF0));
        send_byte(8'hFF, 1, tk(1, 8'hFF));
        send_byte(8'h01, 1, tk(0, 8'h02));
        repeat (3) @(posedge clk);
        #1 out_ready_a = 0;
        send_byte(8'h07, 0, tk(0, 8'h00));
        check("held_valid", 32'(out_valid_a), 1);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        pulse_reset();
        check("flush_out_valid", 32'(out_valid_a), 0);
        check("flush_in_ready", 32'(in_ready_a), 1);
        out_ready_a = 1;
        send_byte(8'h05, 1, tk(0, 8'h05));
        repeat (3) @(posedge clk);
        #1 pulse_reset();
        out_ready_a = 0;
        send_byte(8'h01, 1, tk(0, 8'h01));
        send_byte(8'h02, 1, tk(0, 8'h01));
        exp_a.push_back(tk(0, 8'h01));
        for (int i = 0; i < 7; i++) begin
            in_bit = (i < 2);
            in_valid = 1;
            @(negedge clk);
            check("bp_ready_partial", 32'(in_ready_a), 1);
            @(posedge clk); #1;
        end
        in_bit = 0;
        @(negedge clk);
        check("bp_ready_full", 32'(in_ready_a), 0);
        @(posedge clk); #1;
        out_ready_a = 1;
        @(negedge clk);
        check("bp_pop_same_cycle", 32'(in_ready_a), 0);
        @(posedge clk); #1;
        send_bit(1'b0);
        in_valid = 0;
        repeat (4) @(posedge clk);
        #1 sel = 1;
        send_byte(8'h01, 1, tk(1, 8'h01));
        send_byte(8'h02, 1, tk(0, 8'h01));
        send_byte(8'h03, 1, tk(0, 8'h01));
        send_byte(8'h04, 1, tk(1, 8'h04));
        sel = 0;
        begin
            int n = 0;
            while ((exp_a.size() + exp_b.size()) != 0 && n < 200) begin
                @(posedge clk);
                n++;
            end
        end
        #1 check("drain_left", 32'(exp_a.size() + exp_b.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
